// File: rtl/reaction_session_ctrl.sv
// Session sequencer for the reaction timer: arm delay, stimulus, capture,
// false-start/timeout handling and best/average accumulation.
module reaction_session_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int ROUNDS       = 4,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  parameter int TIMEOUT_MS   = 9999,
  parameter int HOLD_MS      = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_press,
  output logic        waiting,
  output logic        led_on,
  output logic        digits_on,
  output logic [2:0]  round_idx,
  output logic [15:0] disp_ms,
  output logic [15:0] best_ms,
  output logic        false_start,
  output logic        timeout,
  output logic        done
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int RSH = $clog2(ROUNDS);
  localparam logic [15:0] RMASK = 16'((32'd1 << RAND_BITS) - 1);
  localparam logic [PW-1:0] PRE_TC = PW'(TICKS_PER_MS - 1);
  localparam logic [15:0] TMO = 16'(TIMEOUT_MS);
  localparam logic [15:0] HOLD = 16'(HOLD_MS);
  localparam logic [15:0] MIND = 16'(MIN_DELAY_MS);
  localparam logic [2:0] LAST_RND = 3'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STIM,
    S_RESULT,
    S_FALSE,
    S_SUMMARY
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [18:0] sum_q, sum_d;
  logic [15:0] best_q, best_d;
  logic [15:0] disp_q, disp_d;
  logic [2:0]  round_q, round_d;
  logic        tout_q, tout_d;

  logic        tick;
  logic [15:0] ms_nxt;
  logic [15:0] rec;

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    lfsr_d  = lfsr_q;
    sum_d   = sum_q;
    best_d  = best_q;
    disp_d  = disp_q;
    round_d = round_q;
    tout_d  = tout_q;
    tick    = (presc_q == PRE_TC);
    presc_d = tick ? '0 : presc_q + 1'b1;
    ms_nxt  = ms_q + {15'd0, tick};
    ms_d    = ms_nxt;
    rec     = btn_press ? ms_nxt : TMO;

    unique case (state_q)
      S_IDLE, S_SUMMARY: begin
        if (start) begin
          state_d = S_ARM;
          round_d = '0;
          sum_d   = '0;
          best_d  = 16'hFFFF;
          tout_d  = 1'b0;
        end
      end
      S_ARM: begin
        if (btn_press) begin
          state_d = S_FALSE;
          disp_d  = '0;
        end else if (tick && ms_nxt >= delay_q) begin
          state_d = S_STIM;
        end
      end
      S_STIM: begin
        if (btn_press || (tick && ms_nxt >= TMO)) begin
          state_d = S_RESULT;
          tout_d  = !btn_press;
          disp_d  = rec;
          sum_d   = sum_q + {3'd0, rec};
          best_d  = (rec < best_q) ? rec : best_q;
        end
      end
      S_RESULT: begin
        if (tick && ms_nxt >= HOLD) begin
          if (round_q == LAST_RND) begin
            state_d = S_SUMMARY;
            disp_d  = 16'(sum_q >> RSH);
          end else begin
            state_d = S_ARM;
            round_d = round_q + 3'd1;
            tout_d  = 1'b0;
          end
        end
      end
      S_FALSE: begin
        if (tick && ms_nxt >= HOLD) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase

    // every state's timing starts from zero on entry
    if (state_d != state_q) begin
      presc_d = '0;
      ms_d    = '0;
    end

    if (state_d == S_ARM && state_q != S_ARM) begin
      delay_d = MIND + (lfsr_q & RMASK);
      lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      delay_q <= '0;
      lfsr_q  <= 16'hACE1;
      sum_q   <= '0;
      best_q  <= 16'hFFFF;
      disp_q  <= '0;
      round_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      delay_q <= delay_d;
      lfsr_q  <= lfsr_d;
      sum_q   <= sum_d;
      best_q  <= best_d;
      disp_q  <= disp_d;
      round_q <= round_d;
      tout_q  <= tout_d;
    end
  end

  assign waiting     = (state_q == S_IDLE);
  assign led_on      = (state_q == S_STIM);
  assign false_start = (state_q == S_FALSE);
  assign done        = (state_q == S_SUMMARY);
  assign digits_on   = (state_q == S_RESULT) || (state_q == S_FALSE) ||
                       (state_q == S_SUMMARY);
  assign round_idx   = round_q;
  assign disp_ms     = disp_q;
  assign best_ms     = best_q;
  assign timeout     = tout_q;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Directed bench for reaction_session_ctrl with small sim parameters:
// 4 cycles/ms, 2 rounds, 10 ms base delay, 2 random bits, 50 ms cap, 3 ms hold.
module tb_reaction_session_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        btn_press = 1'b0;
  logic        waiting, led_on, digits_on;
  logic [2:0]  round_idx;
  logic [15:0] disp_ms, best_ms;
  logic        false_start, timeout, done;

  int n_vec = 0;
  int n_err = 0;

  reaction_session_ctrl #(
    .TICKS_PER_MS(4),
    .ROUNDS(2),
    .MIN_DELAY_MS(10),
    .RAND_BITS(2),
    .TIMEOUT_MS(50),
    .HOLD_MS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .btn_press(btn_press),
    .waiting(waiting),
    .led_on(led_on),
    .digits_on(digits_on),
    .round_idx(round_idx),
    .disp_ms(disp_ms),
    .best_ms(best_ms),
    .false_start(false_start),
    .timeout(timeout),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  // leaves the bench in the first ARM cycle
  task automatic go_start;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic press;
    btn_press = 1'b1;
    cyc(1);
    btn_press = 1'b0;
  endtask

  // from first ARM cycle to first STIMULUS cycle
  task automatic arm_to_stim(input string tag, input int d);
    cyc(4 * d - 1);
    check({tag, "_led_pre"}, led_on, 0);
    cyc(1);
    check({tag, "_led_on"}, led_on, 1);
  endtask

  // press mid-ms (no tick in that cycle); ends in first RESULT cycle
  task automatic stim_press(input int ms);
    cyc(4 * ms + 1);
    press();
  endtask

  initial begin
    cyc(3);
    check("rst_waiting", waiting, 1);
    check("rst_led", led_on, 0);
    check("rst_digits", digits_on, 0);
    check("rst_round", round_idx, 0);
    check("rst_disp", disp_ms, 0);
    check("rst_best", best_ms, 16'hFFFF);
    check("rst_fs", false_start, 0);
    check("rst_tmo", timeout, 0);
    check("rst_done", done, 0);

    reset = 1'b0;
    cyc(1);
    press();
    check("idle_btn_ignored", waiting, 1);

    // scenario 1+2: full two-round session
    go_start();
    check("s1_waiting", waiting, 0);
    arm_to_stim("s1_r0", 11);
    stim_press(20);
    check("s1_disp", disp_ms, 20);
    check("s1_digits", digits_on, 1);
    check("s1_best", best_ms, 20);
    cyc(11);
    check("s1_hold_end", digits_on, 1);
    cyc(1);
    check("s2_round", round_idx, 1);
    check("s2_digits_off", digits_on, 0);
    arm_to_stim("s2_r1", 10);
    stim_press(30);
    check("s2_disp", disp_ms, 30);
    check("s2_best_kept", best_ms, 20);
    cyc(12);
    check("s2_done", done, 1);
    check("s2_avg", disp_ms, 25);
    check("s2_best", best_ms, 20);
    press();
    check("sum_btn_ignored", done, 1);

    // scenario 3: false start, round repeated, summary excludes it
    do_reset();
    go_start();
    cyc(21);
    press();
    check("s3_fs", false_start, 1);
    check("s3_disp0", disp_ms, 0);
    check("s3_digits", digits_on, 1);
    cyc(11);
    check("s3_fs_hold", false_start, 1);
    cyc(1);
    check("s3_fs_clear", false_start, 0);
    check("s3_round_same", round_idx, 0);
    arm_to_stim("s3_rearm", 10);
    stim_press(8);
    check("s3_r0", disp_ms, 8);
    cyc(12);
    arm_to_stim("s3_r1", 10);
    stim_press(12);
    check("s3_r1", disp_ms, 12);
    check("s3_best", best_ms, 8);
    cyc(12);
    check("s3_done", done, 1);
    check("s3_avg", disp_ms, 10);

    // scenario 4: timeout, then press on the saturating tick
    do_reset();
    go_start();
    arm_to_stim("s4_r0", 11);
    cyc(199);
    check("s4_pre_led", led_on, 1);
    check("s4_pre_tmo", timeout, 0);
    cyc(1);
    check("s4_disp", disp_ms, 50);
    check("s4_tmo", timeout, 1);
    cyc(11);
    check("s4_tmo_hold", timeout, 1);
    cyc(1);
    check("s4_tmo_clear", timeout, 0);
    check("s4_round", round_idx, 1);
    arm_to_stim("s4_r1", 10);
    cyc(199);
    press();
    check("s4_edge_disp", disp_ms, 50);
    check("s4_edge_tmo", timeout, 0);
    cyc(12);
    check("s4_avg", disp_ms, 50);

    // scenario 5: reset mid-STIMULUS
    do_reset();
    go_start();
    arm_to_stim("s5_r0", 11);
    stim_press(7);
    check("s5_best7", best_ms, 7);
    cyc(12);
    arm_to_stim("s5_r1", 10);
    cyc(10);
    reset = 1'b1;
    cyc(1);
    check("s5_led", led_on, 0);
    check("s5_waiting", waiting, 1);
    check("s5_best", best_ms, 16'hFFFF);
    check("s5_round", round_idx, 0);
    check("s5_disp", disp_ms, 0);
    reset = 1'b0;
    cyc(1);
    go_start();
    arm_to_stim("s5_restart", 11);

    // scenario 6: start+btn together in IDLE; stray starts ignored
    do_reset();
    start = 1'b1;
    btn_press = 1'b1;
    cyc(1);
    start = 1'b0;
    btn_press = 1'b0;
    check("s6_armed", waiting, 0);
    check("s6_no_fs", false_start, 0);
    cyc(9);
    go_start();
    check("s6_arm_start", false_start, 0);
    cyc(33);
    check("s6_led_pre", led_on, 0);
    cyc(1);
    check("s6_led_on", led_on, 1);
    cyc(4);
    go_start();
    check("s6_stim_start", led_on, 1);
    cyc(56);
    press();
    check("s6_disp", disp_ms, 15);
    check("s6_round", round_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
